// File: rtl/cmp_seq_nibble.sv
// -----------------------------------------------------------------------------
// cmp_4bit / cmp_seq_nibble
//
// cmp_4bit: combinational 4-bit unsigned magnitude comparator.
//   a_i, b_i         in  4   operands
//   lth_o/equ_o/gth_o out 1  a<b, a==b, a>b (exactly one high)
//
// cmp_seq_nibble: sequential magnitude comparator for wide unsigned operands.
// One shared cmp_4bit examines one nibble per cycle, most significant nibble
// first, and stops at the first nibble that differs. Results are returned
// over a 4-phase req/ack handshake.
//   clk_i    in  1  clock, rising edge
//   rst_ni   in  1  asynchronous active-low reset
//   req_i    in  1  request (4-phase with ack_o)
//   x_i, y_i in  N  unsigned operands, sampled only at acceptance
//   ack_o    out 1  acknowledge; result valid while high
//   lth_o    out 1  x < y (registered, held until next acceptance)
//   equ_o    out 1  x == y
//   gth_o    out 1  x > y
// -----------------------------------------------------------------------------

module cmp_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       lth_o,
    output logic       equ_o,
    output logic       gth_o
);
    assign lth_o = (a_i <  b_i);
    assign equ_o = (a_i == b_i);
    assign gth_o = (a_i >  b_i);
endmodule

module cmp_seq_nibble #(
    parameter int unsigned N = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_i,
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    output logic         ack_o,
    output logic         lth_o,
    output logic         equ_o,
    output logic         gth_o
);
    localparam int unsigned K  = N / 4;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
    // Nibble table padded to a power of two so every idx value selects
    // a defined entry, even when K is not a power of two.
    localparam int unsigned NP = 1 << IW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    xr_q, xr_d;
    logic [N-1:0]    yr_q, yr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            ack_q, ack_d;
    logic            lth_q, lth_d;
    logic            equ_q, equ_d;
    logic            gth_q, gth_d;

    logic [3:0]      xn [NP];
    logic [3:0]      yn [NP];
    logic            c_lth, c_equ, c_gth;

    for (genvar gi = 0; gi < NP; gi++) begin : g_nib
        if (gi < K) begin : g_real
            assign xn[gi] = xr_q[4*gi +: 4];
            assign yn[gi] = yr_q[4*gi +: 4];
        end else begin : g_pad
            assign xn[gi] = 4'h0;
            assign yn[gi] = 4'h0;
        end
    end

    cmp_4bit u_cmp (
        .a_i   (xn[idx_q]),
        .b_i   (yn[idx_q]),
        .lth_o (c_lth),
        .equ_o (c_equ),
        .gth_o (c_gth)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            lth_q   <= 1'b0;
            equ_q   <= 1'b0;
            gth_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            lth_q   <= lth_d;
            equ_q   <= equ_d;
            gth_q   <= gth_d;
        end
    end

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        idx_d   = idx_q;
        ack_d   = ack_q;
        lth_d   = lth_q;
        equ_d   = equ_q;
        gth_d   = gth_q;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    xr_d    = x_i;
                    yr_d    = y_i;
                    idx_d   = IW'(K - 1);
                    lth_d   = 1'b0;
                    equ_d   = 1'b0;
                    gth_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // A req drop here is ignored: the run always completes and
                // DONE then releases ack after a single cycle.
                if (c_lth || c_gth) begin
                    lth_d   = c_lth;
                    gth_d   = c_gth;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    equ_d   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (!req_i) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack_o = ack_q;
    assign lth_o = lth_q;
    assign equ_o = equ_q;
    assign gth_o = gth_q;

endmodule

// File: tb/tb_cmp_seq_nibble.sv
module tb_cmp_seq_nibble;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  req_v;
    logic [15:0] tx, ty;
    logic [2:0]  ack_v, lth_v, equ_v, gth_v;

    int checks = 0;
    int errors = 0;

    // index 0: N=16, 1: N=8, 2: N=4
    cmp_seq_nibble #(.N(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_v[0]), .x_i(tx), .y_i(ty),
        .ack_o(ack_v[0]), .lth_o(lth_v[0]), .equ_o(equ_v[0]), .gth_o(gth_v[0]));
    cmp_seq_nibble #(.N(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_v[1]), .x_i(tx[7:0]), .y_i(ty[7:0]),
        .ack_o(ack_v[1]), .lth_o(lth_v[1]), .equ_o(equ_v[1]), .gth_o(gth_v[1]));
    cmp_seq_nibble #(.N(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_v[2]), .x_i(tx[3:0]), .y_i(ty[3:0]),
        .ack_o(ack_v[2]), .lth_o(lth_v[2]), .equ_o(equ_v[2]), .gth_o(gth_v[2]));

    function automatic int width_of(input int sel);
        return (sel == 0) ? 16 : (sel == 1) ? 8 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: flags {lth,equ,gth} by plain unsigned compare; m = nibbles
    // examined, i.e. position of the first differing nibble from the top.
    task automatic model(input int sel, input logic [15:0] a, input logic [15:0] b,
                         output int m, output logic [2:0] f);
        int n;
        int k;
        logic [15:0] am, bm;
        n  = width_of(sel);
        k  = n / 4;
        am = a & 16'((32'h1 << n) - 1);
        bm = b & 16'((32'h1 << n) - 1);
        f  = {($unsigned(am) < $unsigned(bm)), (am == bm), ($unsigned(am) > $unsigned(bm))};
        m  = k;
        for (int i = k - 1; i >= 0; i--) begin
            if (am[4*i +: 4] != bm[4*i +: 4]) begin
                m = k - i;
                break;
            end
        end
    endtask

    function automatic logic [2:0] flags_of(input int sel);
        return {lth_v[sel], equ_v[sel], gth_v[sel]};
    endfunction

    // Issues a request, optionally corrupts operands / drops req right after
    // acceptance, then measures the latency to ack and checks the result.
    task automatic transact(input int sel, input logic [15:0] a, input logic [15:0] b,
                            input bit scramble, input bit drop_req, output logic [2:0] f);
        int m;
        int lat;
        bit done;
        model(sel, a, b, m, f);
        @(negedge clk);
        tx = a; ty = b; req_v[sel] = 1'b1;
        @(posedge clk);                 // acceptance edge
        @(negedge clk);
        if (scramble) begin
            tx = ~tx; ty = 16'h0000;
        end
        if (drop_req) req_v[sel] = 1'b0;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ack_v[sel] === 1'b1) done = 1'b1;
        end
        $display("txn N=%0d x=%h y=%h latency=%0d exp_latency=%0d flags=%b exp_flags=%b",
                 width_of(sel), a, b, lat, m, flags_of(sel), f);
        check("latency", lat, m);
        check("flags", {29'd0, flags_of(sel)}, {29'd0, f});
    endtask

    task automatic release_req(input int sel, input logic [2:0] f);
        @(negedge clk);
        req_v[sel] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ack_drop", {31'd0, ack_v[sel]}, 32'd0);
        check("flags_held", {29'd0, flags_of(sel)}, {29'd0, f});
    endtask

    initial begin
        logic [2:0] f;
        logic [15:0] ra, rb;
        rst_n = 1'b0; req_v = 3'b000; tx = '0; ty = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("reset_ack", {31'd0, ack_v[s]}, 32'd0);
            check("reset_flags", {29'd0, flags_of(s)}, 32'd0);
        end
        rst_n = 1'b1;

        // Early exit on the top nibble
        transact(0, 16'h2000, 16'h1FFF, 1'b0, 1'b0, f);
        check("early_gth", {31'd0, gth_v[0]}, 32'd1);
        // Asynchronous reset while in DONE
        #2 rst_n = 1'b0;
        #1;
        check("rst_done_ack", {31'd0, ack_v[0]}, 32'd0);
        check("rst_done_flags", {29'd0, flags_of(0)}, 32'd0);
        req_v[0] = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Reset mid-RUN
        @(negedge clk);
        tx = 16'hBEEF; ty = 16'hBEEF; req_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        req_v[0] = 1'b0;
        #1;
        check("rst_run_ack", {31'd0, ack_v[0]}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_run_idle", {31'd0, ack_v[0]}, 32'd0);
        check("rst_run_flags", {29'd0, flags_of(0)}, 32'd0);

        // Last nibble decides
        transact(0, 16'h1234, 16'h1235, 1'b0, 1'b0, f);
        release_req(0, f);
        // Equal operands, result held after release
        transact(0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, f);
        release_req(0, f);
        check("equ_held", {31'd0, equ_v[0]}, 32'd1);

        // req held through DONE: no re-acceptance
        transact(0, 16'h00FF, 16'h0F00, 1'b0, 1'b0, f);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_ack", {31'd0, ack_v[0]}, 32'd1);
        end
        release_req(0, f);
        repeat (3) @(negedge clk);
        check("no_reaccept", {31'd0, ack_v[0]}, 32'd0);

        // Operand changes after acceptance are ignored
        transact(0, 16'h1234, 16'h1235, 1'b1, 1'b0, f);
        release_req(0, f);
        // req dropped during RUN: single-cycle ack
        transact(0, 16'h5000, 16'h5000, 1'b0, 1'b1, f);
        release_req(0, f);

        // N=4 equal
        transact(2, 16'h0003, 16'h0003, 1'b0, 1'b0, f);
        release_req(2, f);
        // N=8 directed
        transact(1, 16'h00A7, 16'h00A9, 1'b0, 1'b0, f);
        release_req(1, f);

        // Random sweep across all widths
        for (int s = 0; s < 3; s++) begin
            for (int t = 0; t < 15; t++) begin
                ra = 16'($urandom);
                rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
                if ($urandom_range(0, 3) == 0) rb = ra ^ 16'(1 << $urandom_range(0, 15));
                transact(s, ra, rb, 1'b0, 1'b0, f);
                release_req(s, f);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
